// File: rtl/la_wb_initiator_if.sv
// Command/response and Wishbone classic signal bundle for la_wb_initiator.
// master = initiator side, slave = command source plus Wishbone target side.
interface la_wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/la_wb_initiator.sv
// Single-beat Wishbone classic initiator driven by a command/response port,
// with a bus timeout that returns ERR_DATA and flags rsp_err.
module la_wb_initiator #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  la_wb_initiator_if.master         bus,
  output logic [15:0]               txn_count,
  output logic [15:0]               err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic [15:0] wait_reg;
  logic        cmd_ready_reg;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic [31:0] rsp_dat_reg;
  logic        cyc_reg;
  logic        we_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [3:0]  sel_reg;
  logic [15:0] txn_reg;
  logic [15:0] err_reg;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_reg     <= IDLE;
      wait_reg      <= 16'd0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_dat_reg   <= 32'd0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= 32'd0;
      dat_reg       <= 32'd0;
      sel_reg       <= 4'd0;
      txn_reg       <= 16'd0;
      err_reg       <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_reg        <= bus.cmd_we;
            adr_reg       <= bus.cmd_adr;
            dat_reg       <= bus.cmd_dat;
            sel_reg       <= bus.cmd_sel;
            cyc_reg       <= 1'b1;
            cmd_ready_reg <= 1'b0;
            wait_reg      <= 16'd0;
            state_reg     <= BUS;
          end
        end
        BUS: begin
          // ack is checked first so a last-cycle ack still completes cleanly
          if (bus.wbm_ack_i) begin
            rsp_dat_reg   <= we_reg ? 32'd0 : bus.wbm_dat_i;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            cyc_reg       <= 1'b0;
            txn_reg       <= txn_reg + 16'd1;
            state_reg     <= RESP;
          end else if (wait_reg == WAIT_LAST) begin
            rsp_dat_reg   <= ERR_DATA;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            cyc_reg       <= 1'b0;
            txn_reg       <= txn_reg + 16'd1;
            if (err_reg != 16'hFFFF) begin
              err_reg <= err_reg + 16'd1;
            end
            state_reg     <= RESP;
          end else begin
            wait_reg <= wait_reg + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
          cyc_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_dat   = rsp_dat_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.wbm_cyc_o = cyc_reg;
  assign bus.wbm_stb_o = cyc_reg;
  assign bus.wbm_we_o  = we_reg;
  assign bus.wbm_adr_o = adr_reg;
  assign bus.wbm_dat_o = dat_reg;
  assign bus.wbm_sel_o = sel_reg;
  assign txn_count     = txn_reg;
  assign err_count     = err_reg;

endmodule
